led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
- Multi-channel LED driver; the parametrised successor of the single fixed-rate blinker.
- One shared prescaler generates a tick. Each of NCH channels runs its own mode: OFF, ON, BLINK at a per-channel period, or CODE (N flashes followed by a gap, repeating).
- Channels are configured at runtime through a valid/ready write port driven by board-level control logic. Outputs go straight to board LED pins.

Parameters:
- CDIV, 50_000_000, clk cycles per tick (>=1; 1 = tick every cycle)
- NCH, 3, number of LED channels (>=1)
- PW, 8, width of per-channel period field (ticks)
- CW, 4, width of per-channel flash-count field
- ACTIVE_LOW, 1, 1 = pin low lights the LED

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous active-low
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted
- cfg_ch  in  CHW=max(1,$clog2(NCH))  target channel
- cfg_mode  in  2  0=OFF 1=ON 2=BLINK 3=CODE
- cfg_period  in  PW  phase length in ticks; 0 treated as 1
- cfg_count  in  CW  flashes per CODE sequence
- tick  out  1  prescaler pulse, one cycle every CDIV cycles
- seq_done  out  NCH  one-cycle pulse per channel at end of each CODE gap
- led  out  NCH  LED pins, lit XOR ACTIVE_LOW

Behaviour:
- Reset is synchronous: on any edge with n_rst=0, all state is cleared.
  - All channels go to OFF; led={NCH{ACTIVE_LOW}}.
  - tick=0, seq_done=0, cfg_ready=0, prescaler=0.
- cfg_ready is registered: 0 during reset, 1 from the first edge with n_rst=1, then held at 1.
- Prescaler counts 0..CDIV-1 and wraps. tick is registered and high for exactly one cycle when the counter wraps.
  - First tick is high CDIV cycles after reset release; subsequent ticks every CDIV cycles.
- Config accept = cfg_valid & cfg_ready at an edge.
  - Mode, period and count are latched into channel cfg_ch.
  - The channel's phase and flash counters clear.
  - lit takes its start value at that same edge: OFF→0, ON→1, BLINK→1, CODE→1 (if count=0, CODE behaves as OFF).
  - led reflects the change the cycle after accept.
  - cfg_ch>=NCH: write is accepted and discarded; no channel changes.
- Channel state advances only on edges where tick=1.
  - Accept to the same channel on a tick edge: config wins and the tick is ignored for that channel.
  - Other channels still advance on that edge.
- OFF/ON: lit constant; tick is ignored.
- BLINK: lit toggles after every Pe ticks, where Pe=max(period,1). Result is Pe ticks on, Pe ticks off, repeating.
- CODE: state machine per channel.
  - States: FLASH_ON(Pe ticks, lit=1) → FLASH_OFF(Pe ticks, lit=0).
  - Flash counter +1 per FLASH_OFF exit. Return to FLASH_ON while flash counter<count; else go to GAP.
  - GAP: GAP_MULT*Pe ticks, lit=0.
  - On GAP exit, seq_done[ch] pulses for one cycle (registered, same edge as the return to FLASH_ON). Flash counter clears and the sequence repeats.
- Phase counter width is PW+$clog2(GAP_MULT)+1, so max period × GAP_MULT cannot overflow.
- Counters compare with ==, never wrap past terminal value. period=2^PW-1 must work.
- seq_done is 0 in every mode except CODE.
- Reset asserted mid-sequence: the next edge forces the reset state regardless of tick or cfg_valid.

Decomposition:
- Package led_seq_pkg:
  - typedef enum logic[1:0] mode_t {MODE_OFF, MODE_ON, MODE_BLINK, MODE_CODE}
  - typedef enum for CODE states {S_FLASH_ON, S_FLASH_OFF, S_GAP}
  - localparam GAP_MULT=4
- Sub-module tick_gen (param CDIV; ports clk, n_rst, tick). Reused by other timing blocks.
- Per-channel logic lives in a generate loop in led_sequencer; no separate channel module.

Test Plan (CDIV=4, NCH=3, PW=8, CW=4, ACTIVE_LOW=1):
1. Reset, then release → led=3'b111, cfg_ready=0 while n_rst=0, cfg_ready=1 one cycle after release; tick every 4th cycle, first 4 cycles after release.
2. Write ch1 BLINK period=2 → led[1]=0 the cycle after accept. led[1] then toggles every 8 clk (2 ticks); ch0/ch2 stay 1.
3. Write ch0 CODE period=1 count=3 → led[0] low/high 1 tick each, three times, then high 4 ticks. seq_done[0] pulses once, then repeats; period 10 ticks = 40 clk.
4. Write ch2 period=0 BLINK → identical to period=1. Write cfg_ch=3 ON → no led change, cfg_ready stays 1.
5. Accept to ch1 (OFF) coincident with tick while ch1 blinks → led[1]=1 next cycle, no toggle. ch0 CODE advances normally that edge.
6. Pull n_rst low mid-CODE for 1 cycle → next edge all led=1, seq_done=0, counters cleared. After release, channels stay OFF until rewritten.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// led_seq_pkg: shared types and constants for the LED sequencer.
//   mode_t      - per-channel operating mode as written over the config port
//   code_st_t   - sub-state of a channel running a CODE sequence
//   GAP_MULT    - CODE inter-sequence gap length, in multiples of the period
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CODE  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_FLASH_ON  = 2'd0,
    S_FLASH_OFF = 2'd1,
    S_GAP       = 2'd2
  } code_st_t;

  localparam int GAP_MULT = 4;

endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: channel configuration write port (valid/ready).
//   cfg_valid  - write request from board control logic
//   cfg_ready  - sequencer can accept a write
//   cfg_ch     - target channel
//   cfg_mode   - 0=OFF 1=ON 2=BLINK 3=CODE
//   cfg_period - phase length in ticks (0 behaves as 1)
//   cfg_count  - flashes per CODE sequence
// master: control logic side; slave: sequencer side.
interface led_sequencer_if #(
  parameter int CHW = 2,
  parameter int PW  = 8,
  parameter int CW  = 4
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [1:0]     cfg_mode;
  logic [PW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_count;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/led_sequencer_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every CDIV clocks.
//   clk    - system clock
//   n_rst  - synchronous active-low reset
//   tick   - registered pulse, first one CDIV cycles after reset release
module tick_gen #(
  parameter int CDIV = 50_000_000
) (
  input  logic clk,
  input  logic n_rst,
  output logic tick
);

  localparam int CNTW = (CDIV > 1) ? $clog2(CDIV) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(CDIV - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CNTW'(1);
    tick_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: multi-channel LED driver sharing one prescaler tick.
// Each channel runs OFF, ON, BLINK (Pe ticks on / Pe ticks off) or CODE
// (count flashes of Pe on / Pe off, then a GAP_MULT*Pe dark gap, repeating).
//   clk       - system clock
//   n_rst     - synchronous active-low reset
//   cfg       - configuration write port (slave side)
//   tick      - prescaler pulse, one cycle every CDIV clocks
//   seq_done  - per-channel pulse at the end of each CODE gap
//   led       - LED pins, lit XOR ACTIVE_LOW
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CDIV       = 50_000_000,
  parameter int NCH        = 3,
  parameter int PW         = 8,
  parameter int CW         = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  led_sequencer_if.slave    cfg,
  output logic              tick,
  output logic [NCH-1:0]    seq_done,
  output logic [NCH-1:0]    led
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  // Wide enough to hold GAP_MULT * (2^PW - 1) without overflow.
  localparam int PHW = PW + $clog2(GAP_MULT) + 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic ready_q;
  logic acc;

  tick_gen #(.CDIV(CDIV)) u_tick_gen (
    .clk   (clk),
    .n_rst (n_rst),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign cfg.cfg_ready = ready_q;
  assign acc           = cfg.cfg_valid & ready_q;

  // Values shared by every channel for the write currently on the port.
  mode_t           new_mode;
  logic [PHW-1:0]  new_pe;
  logic            new_lit;

  assign new_mode = mode_t'(cfg.cfg_mode);
  assign new_pe   = (cfg.cfg_period == '0) ? PHW'(1) : PHW'(cfg.cfg_period);
  // CODE with zero flashes never lights, so it starts dark like OFF.
  assign new_lit  = (new_mode == MODE_ON) || (new_mode == MODE_BLINK) ||
                    ((new_mode == MODE_CODE) && (cfg.cfg_count != '0));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mode_t          mode_q;
    code_st_t       st_q;
    logic [PHW-1:0] pe_q;
    logic [PHW-1:0] phase_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  flash_q;
    logic           lit_q;
    logic           done_q;

    logic           hit;
    logic           ph_end;
    logic           gap_end;
    logic [PHW-1:0] gap_last;

    // Writes to channel numbers >= NCH match no channel and are dropped.
    assign hit      = acc && (cfg.cfg_ch == CHW'(i));
    assign gap_last = PHW'(pe_q * PHW'(GAP_MULT)) - PHW'(1);
    assign ph_end   = (phase_q == pe_q - PHW'(1));
    assign gap_end  = (phase_q == gap_last);

    always_ff @(posedge clk) begin
      if (!n_rst) begin
        mode_q  <= MODE_OFF;
        st_q    <= S_FLASH_ON;
        pe_q    <= PHW'(1);
        phase_q <= '0;
        cnt_q   <= '0;
        flash_q <= '0;
        lit_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        // A write to this channel takes priority over a coincident tick.
        if (hit) begin
          mode_q  <= new_mode;
          pe_q    <= new_pe;
          cnt_q   <= cfg.cfg_count;
          phase_q <= '0;
          flash_q <= '0;
          st_q    <= S_FLASH_ON;
          lit_q   <= new_lit;
        end else if (tick) begin
          case (mode_q)
            MODE_BLINK: begin
              if (ph_end) begin
                phase_q <= '0;
                lit_q   <= ~lit_q;
              end else begin
                phase_q <= phase_q + PHW'(1);
              end
            end
            MODE_CODE: begin
              if (cnt_q != '0) begin
                case (st_q)
                  S_FLASH_ON: begin
                    if (ph_end) begin
                      phase_q <= '0;
                      st_q    <= S_FLASH_OFF;
                      lit_q   <= 1'b0;
                    end else begin
                      phase_q <= phase_q + PHW'(1);
                    end
                  end
                  S_FLASH_OFF: begin
                    if (ph_end) begin
                      phase_q <= '0;
                      if (flash_q == cnt_q - CW'(1)) begin
                        st_q    <= S_GAP;
                        flash_q <= cnt_q;
                      end else begin
                        st_q    <= S_FLASH_ON;
                        flash_q <= flash_q + CW'(1);
                        lit_q   <= 1'b1;
                      end
                    end else begin
                      phase_q <= phase_q + PHW'(1);
                    end
                  end
                  S_GAP: begin
                    if (gap_end) begin
                      phase_q <= '0;
                      flash_q <= '0;
                      st_q    <= S_FLASH_ON;
                      lit_q   <= 1'b1;
                      done_q  <= 1'b1;
                    end else begin
                      phase_q <= phase_q + PHW'(1);
                    end
                  end
                  default: st_q <= S_FLASH_ON;
                endcase
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign led[i]      = lit_q ^ POL;
    assign seq_done[i] = done_q;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: randomized + directed bench for led_sequencer against a
// reference model that derives each LED from the tick count since the last
// write, using the mode's on/off timing arithmetic.
module tb_led_sequencer;
  localparam int CDIV = 4;
  localparam int NCH  = 3;
  localparam int PW   = 8;
  localparam int CW   = 4;
  localparam int AL   = 1;
  localparam int GAPM = 4;

  logic           clk;
  logic           n_rst;
  logic           tick;
  logic [NCH-1:0] seq_done;
  logic [NCH-1:0] led;

  led_sequencer_if #(.CHW(2), .PW(PW), .CW(CW)) cfg_if ();

  led_sequencer #(
    .CDIV(CDIV), .NCH(NCH), .PW(PW), .CW(CW), .ACTIVE_LOW(AL)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .cfg      (cfg_if),
    .tick     (tick),
    .seq_done (seq_done),
    .led      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  bit m_ready;
  bit m_tick;
  int m_cyc;
  int m_mode [NCH];
  int m_pe   [NCH];
  int m_cnt  [NCH];
  int m_t    [NCH];
  bit m_done [NCH];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int code_len(input int c);
    return (2 * m_cnt[c] + GAPM) * m_pe[c];
  endfunction

  function automatic bit model_lit(input int c);
    int r;
    case (m_mode[c])
      1: return 1'b1;
      2: return ((m_t[c] / m_pe[c]) % 2) == 0;
      3: begin
        if (m_cnt[c] == 0) return 1'b0;
        r = m_t[c] % code_len(c);
        return (r < 2 * m_cnt[c] * m_pe[c]) && (((r / m_pe[c]) % 2) == 0);
      end
      default: return 1'b0;
    endcase
  endfunction

  // One clock: capture inputs, apply the edge to the model, compare at negedge.
  task automatic step();
    bit pre_tick, acc, rst_now;
    int ch, md, per, cnt;
    logic [NCH-1:0] e_led, e_done;
    pre_tick = m_tick;
    rst_now  = !n_rst;
    acc      = cfg_if.cfg_valid && m_ready;
    ch       = int'(cfg_if.cfg_ch);
    md       = int'(cfg_if.cfg_mode);
    per      = int'(cfg_if.cfg_period);
    cnt      = int'(cfg_if.cfg_count);
    @(posedge clk);
    if (rst_now) begin
      m_ready = 0; m_tick = 0; m_cyc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_pe[c] = 1; m_cnt[c] = 0; m_t[c] = 0; m_done[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        m_done[c] = 0;
        if (acc && ch == c) begin
          m_mode[c] = md;
          m_pe[c]   = (per == 0) ? 1 : per;
          m_cnt[c]  = cnt;
          m_t[c]    = 0;
        end else if (pre_tick) begin
          m_t[c]++;
          if (m_mode[c] == 3 && m_cnt[c] > 0 && (m_t[c] % code_len(c)) == 0)
            m_done[c] = 1;
        end
      end
      m_ready = 1;
      m_cyc++;
      m_tick = (m_cyc % CDIV) == 0;
    end
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      e_led[c]  = model_lit(c) ^ AL[0];
      e_done[c] = m_done[c];
    end
    chk_eq("led", 32'(led), 32'(e_led));
    chk_eq("seq_done", 32'(seq_done), 32'(e_done));
    chk_eq("tick", 32'(tick), 32'(m_tick));
    chk_eq("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_ready));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cfg_write(input int ch, input int md, input int per, input int cnt);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = 2'(ch);
    cfg_if.cfg_mode   = 2'(md);
    cfg_if.cfg_period = PW'(per);
    cfg_if.cfg_count  = CW'(cnt);
    step();
    cfg_if.cfg_valid  = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_rst = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_mode = '0;
    cfg_if.cfg_period = '0; cfg_if.cfg_count = '0;
    m_ready = 0; m_tick = 0; m_cyc = 0;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_pe[c] = 1; m_cnt[c] = 0; m_t[c] = 0; m_done[c] = 0;
    end
    @(negedge clk);
    run(3);
    n_rst = 1'b1;
    run(12);

    cfg_write(1, 2, 2, 0);          // ch1 BLINK period 2
    run(40);
    cfg_write(0, 3, 1, 3);          // ch0 CODE period 1 count 3
    run(90);
    cfg_write(2, 2, 0, 0);          // period 0 behaves as 1
    run(20);
    cfg_write(3, 1, 5, 2);          // out-of-range channel is dropped
    run(10);

    // Write ch1 OFF on an edge where tick is high.
    found = 0;
    for (int k = 0; k < 2 * CDIV && !found; k++) begin
      if (m_tick) found = 1;
      else step();
    end
    chk_eq("tick_found", 32'(found), 32'd1);
    cfg_write(1, 0, 3, 0);
    run(20);

    // One-cycle reset in the middle of a CODE sequence.
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    run(30);

    cfg_write(2, 2, 255, 0);        // maximum period
    run(2100);
    cfg_write(0, 3, 1, 15);         // maximum flash count
    cfg_write(1, 3, 2, 0);          // CODE with zero flashes stays dark
    run(300);

    for (int it = 0; it < 300; it++) begin
      int idle;
      idle = $urandom_range(0, 20);
      for (int k = 0; k < idle; k++) begin
        cfg_if.cfg_ch   = 2'($urandom_range(0, 3));
        cfg_if.cfg_mode = 2'($urandom_range(0, 3));
        step();
      end
      if ($urandom_range(0, 39) == 0) begin
        n_rst = 1'b0;
        run($urandom_range(1, 2));
        n_rst = 1'b1;
      end
      cfg_write($urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 49) == 0) ? 255 : $urandom_range(0, 4),
                $urandom_range(0, 5));
    end
    run(50);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
